ps2_key_ctrl: RTL and testbench

Game-control decoder directly downstream of the PS/2 scan-code receiver. It consumes the receiver's 10-bit `{expand, break, code}` words and tracks the make/break state of every game key. It also suppresses typematic auto-repeat and turns key activity into clean control signals for the game FSM: a latched jump request with acknowledge, a duck level, a start pulse and a pause toggle. A watchdog clears held keys if a break code is lost.

---
 rtl/ps2_key_pkg.sv | 37 +++
 rtl/key_watchdog.sv | 39 +++
 rtl/ps2_key_ctrl.sv | 77 +++++++
 tb/tb_ps2_key_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// Shared scan codes, held-bit indices and key decode for the PS/2 game-control path.
// A key word is {extended, break, code}; matching ignores the break bit.
package ps2_key_pkg;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam int unsigned KEY_SPACE = 0;
    localparam int unsigned KEY_W_UP  = 1;
    localparam int unsigned KEY_DOWN  = 2;
    localparam int unsigned KEY_S     = 3;
    localparam int unsigned KEY_ENTER = 4;
    localparam int unsigned KEY_P     = 5;
    localparam int unsigned KEY_ESC   = 6;
    localparam int unsigned NUM_KEYS  = 7;

    // One-hot held-bit select for a scan code; all zeros for unmapped codes.
    function automatic logic [NUM_KEYS-1:0] key_hit(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] hit;
        hit            = '0;
        hit[KEY_SPACE] = !ext && (code == SC_SPACE);
        hit[KEY_W_UP]  = (!ext && (code == SC_W)) || (ext && (code == SC_UP));
        hit[KEY_DOWN]  = ext && (code == SC_DOWN);
        hit[KEY_S]     = !ext && (code == SC_S);
        hit[KEY_ENTER] = !ext && (code == SC_ENTER);
        hit[KEY_P]     = !ext && (code == SC_P);
        hit[KEY_ESC]   = !ext && (code == SC_ESC);
        return hit;
    endfunction

endpackage

// File: rtl/key_watchdog.sv
// Idle-time counter for the key decoder: clears on any key event, saturates at the limit
// and pulses timeout during the last cycle before the limit is reached.
module key_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 25_000_000,
    parameter int unsigned CNT_W       = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST   = LIMIT - CNT_W'(1);
    localparam logic             ENABLE = (TIMEOUT_CYC != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires once per idle stretch: the counter then sits at LIMIT until the next event.
    assign timeout = ENABLE && !clr && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Game-control decoder: tracks held keys from PS/2 key words and derives jump request,
// duck level, start/Esc pulses and pause toggle, with typematic repeats suppressed.
module ps2_key_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 25_000_000,
    parameter int unsigned CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_data,
    input  logic       key_valid,
    input  logic       jump_ack,
    output logic       jump_req,
    output logic       duck_held,
    output logic       start_pulse,
    output logic       pause,
    output logic       esc_pulse,
    output logic [6:0] keys_held
);

    import ps2_key_pkg::*;

    logic [NUM_KEYS-1:0] held_q, held_d, hit, rise;
    logic                jump_q, jump_d, jump_set;
    logic                duck_q, start_q, pause_q, esc_q;
    logic                wd_timeout;

    key_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (key_valid),
        .timeout(wd_timeout)
    );

    always_comb begin
        hit    = key_hit(key_data[9], key_data[7:0]);
        held_d = held_q;
        if (key_valid) begin
            held_d = key_data[8] ? (held_q & ~hit) : (held_q | hit);
        end else if (wd_timeout) begin
            held_d = '0;
        end
        // Edges are taken against the previous held state, so auto-repeat makes are silent.
        rise     = held_d & ~held_q;
        jump_set = !(held_q[KEY_SPACE] || held_q[KEY_W_UP]) &&
                   (held_d[KEY_SPACE] || held_d[KEY_W_UP]);
        jump_d   = jump_set || (jump_q && !jump_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q  <= '0;
            jump_q  <= 1'b0;
            duck_q  <= 1'b0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
            esc_q   <= 1'b0;
        end else begin
            held_q  <= held_d;
            jump_q  <= jump_d;
            duck_q  <= held_d[KEY_DOWN] || held_d[KEY_S];
            start_q <= rise[KEY_ENTER];
            pause_q <= pause_q ^ rise[KEY_P];
            esc_q   <= rise[KEY_ESC];
        end
    end

    assign jump_req    = jump_q;
    assign duck_held   = duck_q;
    assign start_pulse = start_q;
    assign pause       = pause_q;
    assign esc_pulse   = esc_q;
    assign keys_held   = held_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: the driver queues hand-computed outputs per cycle,
// a monitor pops and compares them just after each rising edge.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key_data = '0;
    logic       key_valid = 1'b0;
    logic       jump_ack = 1'b0;
    logic       jump_req, duck_held, start_pulse, pause, esc_pulse;
    logic [6:0] keys_held;

    always #5 clk = ~clk;

    ps2_key_ctrl #(
        .TIMEOUT_CYC(100),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_data   (key_data),
        .key_valid  (key_valid),
        .jump_ack   (jump_ack),
        .jump_req   (jump_req),
        .duck_held  (duck_held),
        .start_pulse(start_pulse),
        .pause      (pause),
        .esc_pulse  (esc_pulse),
        .keys_held  (keys_held)
    );

    logic [11:0] exp_q[$];
    int          id_q[$];
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;

    // Expected bundle {jump_req, duck_held, start_pulse, pause, esc_pulse, keys_held}.
    task automatic step(input logic r, input logic kv, input logic [9:0] kd, input logic ack,
                        input logic jr, input logic pa, input logic st, input logic es,
                        input logic [6:0] keys);
        @(negedge clk);
        rst       = r;
        key_valid = kv;
        key_data  = kd;
        jump_ack  = ack;
        step_no++;
        exp_q.push_back({jr, keys[2] | keys[3], st, pa, es, keys});
        id_q.push_back(step_no);
    endtask

    task automatic ev(input logic [9:0] kd, input logic jr, input logic pa, input logic st,
                      input logic es, input logic [6:0] keys);
        step(1'b0, 1'b1, kd, 1'b0, jr, pa, st, es, keys);
    endtask

    task automatic idle(input logic jr, input logic pa, input logic st, input logic es,
                        input logic [6:0] keys);
        step(1'b0, 1'b0, 10'h000, 1'b0, jr, pa, st, es, keys);
    endtask

    task automatic ack(input logic jr, input logic pa, input logic [6:0] keys);
        step(1'b0, 1'b0, 10'h000, 1'b1, jr, pa, 1'b0, 1'b0, keys);
    endtask

    initial begin : monitor
        logic [11:0] e, act;
        int          id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                id  = id_q.pop_front();
                act = {jump_req, duck_held, start_pulse, pause, esc_pulse, keys_held};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL step%0d: got jr/duck/start/pause/esc/keys=%b/%b/%b/%b/%b/%b, expected %b/%b/%b/%b/%b/%b",
                             id, act[11], act[10], act[9], act[8], act[7], act[6:0],
                             e[11], e[10], e[9], e[8], e[7], e[6:0]);
                end
            end
        end
    end

    initial begin : driver
        step(1'b1, 1'b0, 10'h000, 1'b0, 0, 0, 0, 0, 7'b0000000);
        step(1'b1, 1'b1, 10'h029, 1'b0, 0, 0, 0, 0, 7'b0000000);

        // Space: request, typematic, ack, re-arm by break + make
        ev(10'h029, 1, 0, 0, 0, 7'b0000001);
        repeat (3) ev(10'h029, 1, 0, 0, 0, 7'b0000001);
        ack(0, 0, 7'b0000001);
        ev(10'h029, 0, 0, 0, 0, 7'b0000001);
        ev(10'h129, 0, 0, 0, 0, 7'b0000000);
        ev(10'h029, 1, 0, 0, 0, 7'b0000001);
        ack(0, 0, 7'b0000001);
        ev(10'h129, 0, 0, 0, 0, 7'b0000000);
        ack(0, 0, 7'b0000000);

        // Up / W share a bit; set beats a simultaneous ack
        ev(10'h275, 1, 0, 0, 0, 7'b0000010);
        ack(0, 0, 7'b0000010);
        ev(10'h375, 0, 0, 0, 0, 7'b0000000);
        step(1'b0, 1'b1, 10'h01D, 1'b1, 1, 0, 0, 0, 7'b0000010);
        ack(0, 0, 7'b0000010);
        ev(10'h275, 0, 0, 0, 0, 7'b0000010);
        ev(10'h375, 0, 0, 0, 0, 7'b0000000);

        // Duck group and ignored codes
        ev(10'h272, 0, 0, 0, 0, 7'b0000100);
        ev(10'h01B, 0, 0, 0, 0, 7'b0001100);
        ev(10'h372, 0, 0, 0, 0, 7'b0001000);
        ev(10'h11B, 0, 0, 0, 0, 7'b0000000);
        ev(10'h072, 0, 0, 0, 0, 7'b0000000);
        ev(10'h129, 0, 0, 0, 0, 7'b0000000);
        ev(10'h229, 0, 0, 0, 0, 7'b0000000);

        // Enter, P, Esc edges
        ev(10'h05A, 0, 0, 1, 0, 7'b0010000);
        ev(10'h05A, 0, 0, 0, 0, 7'b0010000);
        ev(10'h05A, 0, 0, 0, 0, 7'b0010000);
        ev(10'h15A, 0, 0, 0, 0, 7'b0000000);
        ev(10'h04D, 0, 1, 0, 0, 7'b0100000);
        ev(10'h14D, 0, 1, 0, 0, 7'b0000000);
        ev(10'h04D, 0, 0, 0, 0, 7'b0100000);
        ev(10'h14D, 0, 0, 0, 0, 7'b0000000);
        ev(10'h04D, 0, 1, 0, 0, 7'b0100000);
        ev(10'h04D, 0, 1, 0, 0, 7'b0100000);
        ev(10'h14D, 0, 1, 0, 0, 7'b0000000);
        ev(10'h076, 0, 1, 0, 1, 7'b1000000);
        idle(0, 1, 0, 0, 7'b1000000);
        ev(10'h076, 0, 1, 0, 0, 7'b1000000);
        ev(10'h176, 0, 1, 0, 0, 7'b0000000);

        // Watchdog: Down held, no events; jump_req and pause survive
        ev(10'h029, 1, 1, 0, 0, 7'b0000001);
        ev(10'h129, 1, 1, 0, 0, 7'b0000000);
        ev(10'h272, 1, 1, 0, 0, 7'b0000100);
        for (int i = 1; i <= 99; i++) idle(1, 1, 0, 0, 7'b0000100);
        idle(1, 1, 0, 0, 7'b0000000);
        idle(1, 1, 0, 0, 7'b0000000);
        ev(10'h372, 1, 1, 0, 0, 7'b0000000);

        // Reset with Space held and a pending request
        ack(0, 1, 7'b0000000);
        ev(10'h029, 1, 1, 0, 0, 7'b0000001);
        ev(10'h05A, 1, 1, 1, 0, 7'b0010001);
        step(1'b1, 1'b1, 10'h04D, 1'b1, 0, 0, 0, 0, 7'b0000000);
        ev(10'h129, 0, 0, 0, 0, 7'b0000000);
        ev(10'h15A, 0, 0, 0, 0, 7'b0000000);
        ev(10'h029, 1, 0, 0, 0, 7'b0000001);
        ev(10'h04D, 1, 1, 0, 0, 7'b0100001);

        @(negedge clk);
        key_valid = 1'b0;
        jump_ack  = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
